// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: step modes, ping-pong
// direction and the default 4-LED pattern table.
package led_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_PP   = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int DEF_N_LED = 4;
  localparam int DEF_N_PAT = 4;

  // Entry k sits at bits [k*4 +: 4]; entry 0 (all LEDs off) is the reset pattern.
  localparam logic [15:0] DEF_PAT_TABLE = {4'b0110, 4'b1001, 4'b0011, 4'b0000};

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, restartable via clr.
module tick_gen #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == TOP)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/led_pattern_seq.sv
// Pattern-table LED sequencer: index loaded or stepped (hold/up/down/ping-pong)
// on a prescaled tick. Optional LED_BLINK_EN adds a blink input gated by tick phase.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int N_LED = DEF_N_LED,
  parameter int N_PAT = DEF_N_PAT,
  parameter int DIV   = 50000000,
  parameter logic [N_LED*N_PAT-1:0] PAT_TABLE = DEF_PAT_TABLE,
  localparam int PW = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PW-1:0]    num_in,
  input  logic             load,
  input  logic             run,
  input  logic [1:0]       mode,
`ifdef LED_BLINK_EN
  input  logic             blink,
`endif
  output logic [N_LED-1:0] leds,
  output logic [PW-1:0]    index,
  output logic             tick
);

  localparam logic [PW-1:0] LAST     = PW'(N_PAT - 1);
  localparam logic [PW:0]   NPAT_EXT = (PW + 1)'(N_PAT);

  dir_t             dir, dir_nxt;
  logic [PW-1:0]    idx_nxt;
  logic [N_LED-1:0] leds_nxt;
  logic             step;
  logic             go_up;

  function automatic logic [N_LED-1:0] pat_at(input logic [PW-1:0] k);
    return PAT_TABLE[int'(k)*N_LED +: N_LED];
  endfunction

  // A load restarts the prescaler so the next step lands a full DIV later.
  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    step    = tick & run & (mode != MODE_HOLD);
    idx_nxt = index;
    dir_nxt = dir;
    go_up   = 1'b0;
    if (load) begin
      idx_nxt = ({1'b0, num_in} < NPAT_EXT) ? num_in : LAST;
    end else if (step && (N_PAT > 1)) begin
      case (mode)
        MODE_UP:   idx_nxt = (index == LAST) ? '0 : index + 1'b1;
        MODE_DOWN: idx_nxt = (index == '0) ? LAST : index - 1'b1;
        MODE_PP: begin
          // At an end with dir pointing outward, bounce inward on this same step.
          go_up   = (dir == DIR_UP) ? (index != LAST) : (index == '0);
          idx_nxt = go_up ? index + 1'b1 : index - 1'b1;
          if (idx_nxt == LAST)    dir_nxt = DIR_DOWN;
          else if (idx_nxt == '0) dir_nxt = DIR_UP;
          else                    dir_nxt = go_up ? DIR_UP : DIR_DOWN;
        end
        default: ;
      endcase
    end
  end

`ifdef LED_BLINK_EN
  logic phase;
  logic phase_nxt;

  assign phase_nxt = phase ^ tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 1'b0;
    else        phase <= phase_nxt;
  end

  assign leds_nxt = (blink && phase_nxt) ? '0 : pat_at(idx_nxt);
`else
  assign leds_nxt = pat_at(idx_nxt);
`endif

  // leds is loaded from the next index, so it never lags index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      dir   <= DIR_UP;
      leds  <= PAT_TABLE[N_LED-1:0];
    end else begin
      index <= idx_nxt;
      dir   <= dir_nxt;
      leds  <= leds_nxt;
    end
  end

endmodule
